ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Two-requester round-robin arbiter that shares the read/write port of the dual-port instruction/data SRAM between the Ibex data interface (requester 0) and a second bus master, e.g. a debug or UART loader (requester 1). It sits between both masters and the RAM's req/we/be/addr/wdata port. It issues at most one RAM access per cycle and routes each 1-cycle-latency response back to the requester that issued it. The RAM's second, read-only port is not touched by this block.

## Interface
- Depth, 128: RAM depth in 32-bit words; must be a power of two, at least 2.
- Base, 32'h0010_0000: byte base address of the RAM window.
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- m_req_i  in  2  per-requester request, bit k = requester k
- m_we_i  in  2  per-requester write enable
- m_be_i  in  2x4  per-requester byte enables
- m_addr_i  in  2x32  per-requester byte address
- m_wdata_i  in  2x32  per-requester write data
- m_gnt_o  out  2  grant, combinational, same cycle as the request
- m_rvalid_o  out  2  response valid, one cycle after grant
- m_rdata_o  out  2x32  response data; valid only while the matching m_rvalid_o is high
- m_err_o  out  2  response error, qualified by m_rvalid_o
- ram_req_o, ram_we_o  out  1, 1  request and write enable to the RAM port
- ram_be_o  out  4  byte enables to the RAM port
- ram_addr_o, ram_wdata_o  out  32, 32  byte address and write data to the RAM port
- ram_rvalid_i  in  1  RAM response valid
- ram_rdata_i  in  32  RAM read data

## Operation
- Arbitration, combinational on m_req_i and the priority register last_q:
  - Only one requester asserts req: that requester is granted.
  - Both assert req: the requester that is not last_q is granted.
  - Exactly one m_gnt_o bit is high in any cycle with a request. No bit is high when m_req_i = 0.
- The granted requester's we/be/addr/wdata are muxed onto ram_*. ram_req_o = |m_gnt_o (except for a range error, see Configuration).
- Bookkeeping on every grant:
  - last_q <= granted index.
  - own_q <= granted index.
  - pend_q <= 1.
- Cycles with no grant: pend_q <= 0; own_q and last_q hold.
- Response routing:
  - m_rvalid_o[k] = pend_q & (own_q == k) & ram_rvalid_i.
  - m_rdata_o[k] = ram_rdata_i. It is don't-care when not valid; the bench must not check it then.
- Writes also produce an rvalid, with don't-care rdata and err = 0.
- An ungranted requester keeps req and its payload stable until granted. Master-side protocol checks must flag any violation of this.
- The block is fully pipelined: a new grant is allowed every cycle, including the cycle in which the previous response returns.

## Timing
- Reset values:
  - last_q = 1, so requester 0 wins the first contention.
  - own_q = 0, pend_q = 0, err_q = 0.
  - All m_rvalid_o = 0, m_err_o = 0.
- Latency: grant in cycle N → m_rvalid_o in cycle N+1. There is no added arbitration cycle.
- Back-to-back contention: requesters alternate each cycle (0,1,0,1…). Neither can starve; the worst-case wait is 1 cycle.
- Reset asserted while an access is outstanding: pend_q clears, and any ram_rvalid_i in the next cycle is dropped (no m_rvalid_o). A write issued in the same cycle as reset still reaches the RAM.
- RAM address handling: ram_addr_o is the granted address passed through unmodified. The RAM itself decodes word index bits [log2(Depth)+1:2].

## Configuration
- RAM_ARB_RANGE_CHK_EN defined:
  - A granted request with offset = addr − Base ≥ Depth*4 is still granted, but ram_req_o = 0, so no RAM access and no write.
  - err_q <= 1 for that grant.
  - Next cycle: m_rvalid_o[own_q] = 1, m_err_o = 1, m_rdata_o = 0. This response is generated internally, independent of ram_rvalid_i.
  - Comparison is unsigned 32-bit, so addresses below Base also error via wrap-around.
- RAM_ARB_RANGE_CHK_EN undefined:
  - No range check; every grant drives ram_req_o.
  - m_err_o is tied to 0.
  - Out-of-window addresses alias modulo Depth.

## Test plan
- Single read: m0 reads Base+0x10 holding 0xDEADBEEF → m_gnt_o = 01 in the same cycle; next cycle m_rvalid_o = 01, m_rdata_o[0] = 0xDEADBEEF.
- Contention: both requesters hold req for 4 cycles right after reset → grants 0,1,0,1; each rvalid goes only to the matching owner one cycle later.
- Byte write: m1 writes 0x11223344 with be = 4'b0101, then reads the same word → RAM merged correctly; m1 gets two rvalids and m0 gets none.
- Reset mid-access: m0 is granted a read in cycle N and rst_i is high in cycle N+1 → m_rvalid_o stays 00; after reset, the first contention grants m0.
- RAM_ARB_RANGE_CHK_EN defined: m1 writes Base+Depth*4 → ram_req_o = 0, the RAM is unchanged, and the next cycle gives m_rvalid_o = 10, m_err_o = 10, rdata = 0.
- RAM_ARB_RANGE_CHK_EN undefined, same stimulus as above → the write lands at word 0 and m_err_o = 00.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one SRAM read/write port between two bus masters.
// Optional range check against the RAM window: define RAM_ARB_RANGE_CHK_EN.
module ram_port_arbiter #(
    parameter int unsigned DEPTH = 128,
    parameter logic [31:0] BASE  = 32'h0010_0000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [1:0]       m_req_i,
    input  logic [1:0]       m_we_i,
    input  logic [1:0][3:0]  m_be_i,
    input  logic [1:0][31:0] m_addr_i,
    input  logic [1:0][31:0] m_wdata_i,
    output logic [1:0]       m_gnt_o,
    output logic [1:0]       m_rvalid_o,
    output logic [1:0][31:0] m_rdata_o,
    output logic [1:0]       m_err_o,
    output logic             ram_req_o,
    output logic             ram_we_o,
    output logic [3:0]       ram_be_o,
    output logic [31:0]      ram_addr_o,
    output logic [31:0]      ram_wdata_o,
    input  logic             ram_rvalid_i,
    input  logic [31:0]      ram_rdata_i
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("ram_port_arbiter: DEPTH must be a power of two, at least 2");
    end
    if (BASE[1:0] != 2'b00) begin : g_bad_base
        $error("ram_port_arbiter: BASE must be word aligned");
    end

    logic       last_q;
    logic       own_q;
    logic       pend_q;
    logic       err_q;
    logic       sel;
    logic       any_gnt;
    logic       range_err;
    logic       rsp;

    // last_q names the previous winner, so the other requester wins a tie
    always_comb begin
        m_gnt_o = 2'b00;
        case (m_req_i)
            2'b01:   m_gnt_o = 2'b01;
            2'b10:   m_gnt_o = 2'b10;
            2'b11:   m_gnt_o = last_q ? 2'b01 : 2'b10;
            default: m_gnt_o = 2'b00;
        endcase
    end

    assign any_gnt = |m_gnt_o;
    assign sel     = m_gnt_o[1];

    assign ram_we_o    = m_we_i[sel];
    assign ram_be_o    = m_be_i[sel];
    assign ram_addr_o  = m_addr_i[sel];
    assign ram_wdata_o = m_wdata_i[sel];

`ifdef RAM_ARB_RANGE_CHK_EN
    localparam logic [31:0] WIN_BYTES = 32'(DEPTH * 4);

    // Unsigned compare: addresses below BASE wrap to a huge offset and fail too
    assign range_err = any_gnt && ((m_addr_i[sel] - BASE) >= WIN_BYTES);
`else
    assign range_err = 1'b0;
`endif

    assign ram_req_o = any_gnt & ~range_err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
            own_q  <= 1'b0;
            pend_q <= 1'b0;
            err_q  <= 1'b0;
        end else if (any_gnt) begin
            last_q <= sel;
            own_q  <= sel;
            pend_q <= 1'b1;
            err_q  <= range_err;
        end else begin
            pend_q <= 1'b0;
            err_q  <= 1'b0;
        end
    end

    // A response landing in a reset cycle is dropped; range errors answer without the RAM
    assign rsp = pend_q & ~rst_i & (ram_rvalid_i | err_q);

    assign m_rvalid_o = {rsp & own_q, rsp & ~own_q};

`ifdef RAM_ARB_RANGE_CHK_EN
    assign m_err_o = m_rvalid_o & {2{err_q}};
`else
    assign m_err_o = 2'b00;
`endif

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            m_rdata_o[k] = err_q ? 32'h0 : ram_rdata_i;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized bench for ram_port_arbiter with a behavioural RAM and reference model.
// Covers both builds of RAM_ARB_RANGE_CHK_EN.
module tb_ram_port_arbiter;

    localparam int          DEPTH = 128;
    localparam int          AW    = $clog2(DEPTH);
    localparam logic [31:0] BASE  = 32'h0010_0000;

    logic             clk_i;
    logic             rst_i;
    logic [1:0]       m_req_i;
    logic [1:0]       m_we_i;
    logic [1:0][3:0]  m_be_i;
    logic [1:0][31:0] m_addr_i;
    logic [1:0][31:0] m_wdata_i;
    logic [1:0]       m_gnt_o;
    logic [1:0]       m_rvalid_o;
    logic [1:0][31:0] m_rdata_o;
    logic [1:0]       m_err_o;
    logic             ram_req_o;
    logic             ram_we_o;
    logic [3:0]       ram_be_o;
    logic [31:0]      ram_addr_o;
    logic [31:0]      ram_wdata_o;
    logic             ram_rvalid_i;
    logic [31:0]      ram_rdata_i;

    int checks   = 0;
    int failures = 0;

    ram_port_arbiter #(.DEPTH(DEPTH), .BASE(BASE)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m_req_i(m_req_i), .m_we_i(m_we_i), .m_be_i(m_be_i),
        .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i),
        .m_gnt_o(m_gnt_o), .m_rvalid_o(m_rvalid_o),
        .m_rdata_o(m_rdata_o), .m_err_o(m_err_o),
        .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_be_o(ram_be_o),
        .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
        .ram_rvalid_i(ram_rvalid_i), .ram_rdata_i(ram_rdata_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'hDEAD_BEEF;
        if (i == 5) return 32'hAABB_CCDD;
        return 32'h1357_9BDF ^ (32'(i) * 32'h0101_0101);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural single-port RAM with one cycle read latency
    logic [31:0] ram_mem [DEPTH];
    bit          ram_loaded = 1'b0;

    always @(posedge clk_i) begin
        if (!ram_loaded) begin
            for (int i = 0; i < DEPTH; i++) ram_mem[i] <= init_word(i);
            ram_loaded   <= 1'b1;
            ram_rvalid_i <= 1'b0;
            ram_rdata_i  <= 32'h0;
        end else begin
            ram_rvalid_i <= ram_req_o;
            if (ram_req_o) begin
                ram_rdata_i <= ram_mem[ram_addr_o[AW+1:2]];
                if (ram_we_o) begin
                    for (int b = 0; b < 4; b++)
                        if (ram_be_o[b]) ram_mem[ram_addr_o[AW+1:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
                end
            end else begin
                ram_rdata_i <= $urandom;
            end
        end
    end

    // Reference model: last winner, one outstanding response record, shadow memory
    logic [31:0]      shadow [DEPTH];
    bit               sh_loaded = 1'b0;
    int               m_last    = 1;
    bit               rsp_v     = 1'b0;
    int               rsp_own   = 0;
    bit               rsp_we    = 1'b0;
    bit               rsp_err   = 1'b0;
    logic [31:0]      rsp_data  = 32'h0;
    bit               p_valid   = 1'b0;
    logic [1:0]       p_req, p_gnt, p_we;
    logic [1:0][3:0]  p_be;
    logic [1:0][31:0] p_addr, p_wd;

    always @(negedge clk_i) begin : cmp
        logic [1:0] ev;
        logic [1:0] eg;
        int         g;
        int         idx;
        bit         oob;
        if (!sh_loaded) begin
            for (int i = 0; i < DEPTH; i++) shadow[i] = init_word(i);
            sh_loaded = 1'b1;
        end
        ev = 2'b00;
        if (rsp_v && !rst_i) ev[rsp_own] = 1'b1;
        chk("rvalid", 32'(m_rvalid_o), 32'(ev));
        for (int k = 0; k < 2; k++) begin
            if (ev[k]) begin
                chk("err", 32'(m_err_o[k]), 32'(rsp_err));
                if (rsp_err)      chk("rdata_err", m_rdata_o[k], 32'h0);
                else if (!rsp_we) chk("rdata", m_rdata_o[k], rsp_data);
            end
        end
        case (m_req_i)
            2'b00:   g = -1;
            2'b01:   g = 0;
            2'b10:   g = 1;
            default: g = 1 - m_last;
        endcase
        eg = 2'b00;
        if (g >= 0) eg[g] = 1'b1;
        chk("gnt", 32'(m_gnt_o), 32'(eg));
        rsp_v = 1'b0;
        oob   = 1'b0;
        if (g >= 0) begin
            idx = int'(m_addr_i[g][AW+1:2]);
`ifdef RAM_ARB_RANGE_CHK_EN
            oob = (m_addr_i[g] - BASE) >= 32'(DEPTH * 4);
`endif
            chk("ram_req", 32'(ram_req_o), 32'(!oob));
            if (!oob) begin
                chk("ram_addr", ram_addr_o, m_addr_i[g]);
                chk("ram_we", 32'(ram_we_o), 32'(m_we_i[g]));
                if (m_we_i[g]) begin
                    chk("ram_be", 32'(ram_be_o), 32'(m_be_i[g]));
                    chk("ram_wdata", ram_wdata_o, m_wdata_i[g]);
                end
            end
            rsp_v    = !rst_i;
            rsp_own  = g;
            rsp_we   = m_we_i[g];
            rsp_err  = oob;
            rsp_data = shadow[idx];
            if (m_we_i[g] && !oob) begin
                for (int b = 0; b < 4; b++)
                    if (m_be_i[g][b]) shadow[idx][8*b +: 8] = m_wdata_i[g][8*b +: 8];
            end
        end else begin
            chk("ram_req_idle", 32'(ram_req_o), 32'h0);
        end
        m_last = rst_i ? 1 : ((g >= 0) ? g : m_last);
        // Master-side protocol: an ungranted request must stay put
        if (p_valid) begin
            for (int k = 0; k < 2; k++) begin
                if (p_req[k] && !p_gnt[k])
                    chk("master_hold",
                        32'(m_req_i[k] && m_we_i[k] == p_we[k] && m_be_i[k] == p_be[k] &&
                            m_addr_i[k] == p_addr[k] && m_wdata_i[k] == p_wd[k]), 32'h1);
            end
        end
        p_valid = 1'b1;
        p_req   = m_req_i;
        p_gnt   = m_gnt_o;
        p_we    = m_we_i;
        p_be    = m_be_i;
        p_addr  = m_addr_i;
        p_wd    = m_wdata_i;
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic setm(input int k, input bit req, input bit we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wd);
        m_req_i[k]   = req;
        m_we_i[k]    = we;
        m_be_i[k]    = be;
        m_addr_i[k]  = addr;
        m_wdata_i[k] = wd;
    endtask

    task automatic new_txn(input int k);
        int          r;
        logic [31:0] a;
        r = $urandom_range(0, 9);
        a = $urandom;
        if (r == 0)      a = {a[31:2], 2'b00};
        else if (r == 1) a = BASE - 32'd4;
        else             a = BASE + 32'(4 * $urandom_range(0, 15));
        setm(k, 1'b1, 1'($urandom_range(0, 1)), 4'($urandom), a, $urandom);
    endtask

    initial begin : stim
        logic [1:0] gcap;
        rst_i = 1'b1;
        setm(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        setm(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (3) begin
            @(negedge clk_i);
            chk("lit_rst_rvalid", 32'(m_rvalid_o), 32'h0);
            chk("lit_rst_err", 32'(m_err_o), 32'h0);
        end

        // Contention right after reset: 0,1,0,1 then m0 once more
        step(); rst_i = 1'b0;
        setm(0, 1'b1, 1'b0, 4'hF, BASE + 32'h20, 32'h0);
        setm(1, 1'b1, 1'b0, 4'hF, BASE + 32'h24, 32'h0);
        @(negedge clk_i); chk("lit_cont_g0", 32'(m_gnt_o), 32'h1); chk("lit_cont_v0", 32'(m_rvalid_o), 32'h0);
        step();
        @(negedge clk_i); chk("lit_cont_g1", 32'(m_gnt_o), 32'h2); chk("lit_cont_v1", 32'(m_rvalid_o), 32'h1);
        step();
        @(negedge clk_i); chk("lit_cont_g2", 32'(m_gnt_o), 32'h1); chk("lit_cont_v2", 32'(m_rvalid_o), 32'h2);
        step();
        @(negedge clk_i); chk("lit_cont_g3", 32'(m_gnt_o), 32'h2); chk("lit_cont_v3", 32'(m_rvalid_o), 32'h1);
        step(); setm(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk_i); chk("lit_cont_g4", 32'(m_gnt_o), 32'h1); chk("lit_cont_v4", 32'(m_rvalid_o), 32'h2);
        step(); setm(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk_i); chk("lit_idle_g", 32'(m_gnt_o), 32'h0); chk("lit_cont_v5", 32'(m_rvalid_o), 32'h1);

        // Single read
        step(); setm(0, 1'b1, 1'b0, 4'hF, BASE + 32'h10, 32'h0);
        @(negedge clk_i); chk("lit_rd_gnt", 32'(m_gnt_o), 32'h1);
        step(); setm(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk_i); chk("lit_rd_v", 32'(m_rvalid_o), 32'h1); chk("lit_rd_data", m_rdata_o[0], 32'hDEAD_BEEF);

        // Byte write then read back
        step(); setm(1, 1'b1, 1'b1, 4'b0101, BASE + 32'h14, 32'h1122_3344);
        @(negedge clk_i); chk("lit_bw_gnt", 32'(m_gnt_o), 32'h2);
        step(); setm(1, 1'b1, 1'b0, 4'hF, BASE + 32'h14, 32'h0);
        @(negedge clk_i); chk("lit_bw_v", 32'(m_rvalid_o), 32'h2); chk("lit_bw_gnt2", 32'(m_gnt_o), 32'h2);
        step(); setm(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk_i); chk("lit_bw_v2", 32'(m_rvalid_o), 32'h2); chk("lit_bw_data", m_rdata_o[1], 32'hAA22_CC44);

        // Reset while a read is outstanding
        step(); setm(0, 1'b1, 1'b0, 4'hF, BASE + 32'h8, 32'h0);
        @(negedge clk_i); chk("lit_rm_gnt", 32'(m_gnt_o), 32'h1);
        step(); setm(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0); rst_i = 1'b1;
        @(negedge clk_i); chk("lit_rm_drop", 32'(m_rvalid_o), 32'h0);
        step(); rst_i = 1'b0;
        setm(0, 1'b1, 1'b0, 4'hF, BASE + 32'h0C, 32'h0);
        setm(1, 1'b1, 1'b0, 4'hF, BASE + 32'h1C, 32'h0);
        @(negedge clk_i); chk("lit_rm_first", 32'(m_gnt_o), 32'h1); chk("lit_rm_v", 32'(m_rvalid_o), 32'h0);
        step(); setm(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk_i); chk("lit_rm_second", 32'(m_gnt_o), 32'h2);
        step(); setm(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk_i); chk("lit_rm_v2", 32'(m_rvalid_o), 32'h2);

        // Write one word past the window
        step(); setm(1, 1'b1, 1'b1, 4'hF, BASE + 32'(DEPTH * 4), 32'hCAFE_F00D);
        @(negedge clk_i);
        chk("lit_oob_gnt", 32'(m_gnt_o), 32'h2);
`ifdef RAM_ARB_RANGE_CHK_EN
        chk("lit_oob_req", 32'(ram_req_o), 32'h0);
`else
        chk("lit_oob_req", 32'(ram_req_o), 32'h1);
`endif
        step(); setm(1, 1'b1, 1'b0, 4'hF, BASE, 32'h0);
        @(negedge clk_i);
        chk("lit_oob_v", 32'(m_rvalid_o), 32'h2);
`ifdef RAM_ARB_RANGE_CHK_EN
        chk("lit_oob_err", 32'(m_err_o), 32'h2);
        chk("lit_oob_rdata", m_rdata_o[1], 32'h0);
`else
        chk("lit_oob_err", 32'(m_err_o), 32'h0);
`endif
        step(); setm(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk_i);
        chk("lit_w0_v", 32'(m_rvalid_o), 32'h2);
`ifdef RAM_ARB_RANGE_CHK_EN
        chk("lit_w0_data", m_rdata_o[1], 32'h1357_9BDF);
`else
        chk("lit_w0_data", m_rdata_o[1], 32'hCAFE_F00D);
`endif

        // Randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_i);
            gcap = m_gnt_o;
            step();
            rst_i = ($urandom_range(0, 99) == 0);
            for (int k = 0; k < 2; k++) begin
                if (!(m_req_i[k] && !gcap[k])) begin
                    if ($urandom_range(0, 3) != 0) new_txn(k);
                    else setm(k, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
                end
            end
        end

        @(negedge clk_i);
        gcap = m_gnt_o;
        step();
        rst_i = 1'b0;
        for (int k = 0; k < 2; k++)
            if (!(m_req_i[k] && !gcap[k])) setm(k, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (4) step();
        setm(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        setm(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (3) step();
        for (int i = 0; i < DEPTH; i++) chk("mem_contents", ram_mem[i], shadow[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
